// File: rtl/psum_drain.sv
// psum_drain: de-skews the bottom-row PE partial-sum stream into aligned row vectors and FIFO-buffers them for writeback.
// Optional macro PSUM_RELU_EN zeroes sign-set lanes at FIFO write.
module psum_drain #(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EN,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [COLS*32-1:0] in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLS*32-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               ovf
);
    localparam int W  = COLS * 32;
    localparam int AW = $clog2(DEPTH);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    state_t state_q, state_d;

    logic [W-1:0]  row;
    logic [W-1:0]  wdata;
    logic          push_req, tok, push, pop, is_last;
    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic [RW-1:0] rc_q;
    logic [W-1:0]  hold_q;

    // lane j waits COLS-1-j EN-steps so all lanes line up at the push edge
    for (genvar j = 0; j < COLS; j++) begin : g_lane
        if (j == COLS - 1) begin : g_direct
            assign row[32*j +: 32] = in_sum[32*j +: 32];
        end else begin : g_dly
            logic [31:0] dl_q [COLS-1-j];
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    for (int k = 0; k < COLS - 1 - j; k++) dl_q[k] <= '0;
                end else if (EN) begin
                    dl_q[0] <= in_sum[32*j +: 32];
                    for (int k = 1; k < COLS - 1 - j; k++) dl_q[k] <= dl_q[k-1];
                end
            end
            assign row[32*j +: 32] = dl_q[COLS-2-j];
        end
    end

    if (COLS == 1) begin : g_nopipe
        assign push_req = EN & in_valid;
        assign tok      = 1'b0;
    end else begin : g_vpipe
        logic [COLS-2:0] vp_q;
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET)     vp_q <= '0;
            else if (flush) vp_q <= '0;
            else if (EN)    vp_q <= (vp_q << 1) | (COLS-1)'(in_valid);
        end
        assign push_req = EN & vp_q[COLS-2];
        assign tok      = |vp_q;
    end

    always_comb begin
        wdata = row;
`ifdef PSUM_RELU_EN
        for (int j = 0; j < COLS; j++)
            if (row[32*j+31]) wdata[32*j +: 32] = 32'h0;
`endif
        pop     = ~flush & out_valid & out_ready;
        push    = ~flush & push_req & ((cnt_q != (AW+1)'(DEPTH)) | pop);
        is_last = rc_q == RW'(ROWS - 1);
    end

    assign out_valid = cnt_q != '0;
    assign out_data  = out_valid ? mem_q[rp_q][W-1:0] : hold_q;
    assign out_last  = out_valid & mem_q[rp_q][W];
    assign busy      = state_q != IDLE;

    always_ff @(posedge CLK) begin
        if (push) mem_q[wp_q] <= {is_last, wdata};
    end

    // a full FIFO still accepts a push when the head is popped in the same cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            rc_q   <= '0;
            ovf    <= 1'b0;
            hold_q <= '0;
        end else if (flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            rc_q  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
                rc_q <= is_last ? '0 : rc_q + 1'b1;
            end
            if (pop) begin
                rp_q   <= rp_q + 1'b1;
                hold_q <= out_data;
            end
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push_req & ~push) ovf <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = IDLE;
        else if (EN & in_valid & (state_q != FILL))
            state_d = FILL;
        else if ((state_q == FILL) & push & is_last)
            state_d = DRAIN;
        else if ((state_q == DRAIN) & ~out_valid & ~tok)
            state_d = IDLE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end
endmodule
